regfile_mp: RTL and testbench

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard. It replaces the fixed 32x32, one-write/two-read flop register file in the RISC-V core and serves dual-issue and long-latency (load/divide) writeback. Writes are synchronous and reads are asynchronous. Busy bits let issue logic stall on pending producers.

---
 rtl/regfile_mp.sv | 153 +++++++++++++++
 tb/tb_regfile_mp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-port integer register file with write-to-read bypass and
// a per-register busy scoreboard. Writes are synchronous, reads asynchronous.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   register index width, depth = 2**ADDR_W
//   NUM_RD   number of read ports (1..4)
//   NUM_WR   number of write ports (1..2), higher index has priority
//   BYPASS   1 = same-cycle write data/busy-clear forwarded to reads
//   ZERO_REG 1 = register 0 reads as zero, is never written, never busy
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   wr_en_i     per-port write enable
//   wr_addr_i   write indices, port p at [p*ADDR_W +: ADDR_W]
//   wr_data_i   write data, port p at [p*DATA_W +: DATA_W]
//   rd_addr_i   read indices, port r at [r*ADDR_W +: ADDR_W]
//   rd_data_o   read data (combinational), port r at [r*DATA_W +: DATA_W]
//   rd_busy_o   selected register has a pending producer
//   sb_set_i    mark register sb_addr_i busy
//   sb_addr_i   scoreboard set index
//   busy_vec_o  registered busy bits, bit n = register n
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     sb_set_i,
  input  logic [ADDR_W-1:0]        sb_addr_i,
  output logic [(1<<ADDR_W)-1:0]   busy_vec_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // Elaboration-time parameter range checks.
  generate
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be in 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
      $error("regfile_mp: NUM_WR must be in 1..2");
    end
  endgenerate

  // Unpacked views of the flattened port buses.
  logic [ADDR_W-1:0] wr_addr [NUM_WR];
  logic [DATA_W-1:0] wr_data [NUM_WR];
  logic              wr_live [NUM_WR];
  logic [ADDR_W-1:0] rd_addr [NUM_RD];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_port
      assign wr_addr[gi] = wr_addr_i[gi*ADDR_W +: ADDR_W];
      assign wr_data[gi] = wr_data_i[gi*DATA_W +: DATA_W];
      // A write to x0 is dropped entirely when x0 is hard-wired, so it neither
      // updates storage nor forwards nor clears busy.
      assign wr_live[gi] = wr_en_i[gi] &&
                           !((ZERO_REG != 0) && (wr_addr[gi] == '0));
    end
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
      assign rd_addr[gi] = rd_addr_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Next-state storage: ports applied in ascending order so the highest
  // enabled port to a shared address is the last assignment and wins.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_live[p]) begin
        mem_d[wr_addr[p]] = wr_data[p];
      end
    end
    // Keeps x0 a constant so synthesis removes its flops.
    if (ZERO_REG != 0) begin
      mem_d[0] = '0;
    end
  end

  // Scoreboard: retiring writes clear first, then a new producer sets, so a
  // set/clear collision on the same register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_live[p]) begin
        busy_d[wr_addr[p]] = 1'b0;
      end
    end
    if (sb_set_i && !((ZERO_REG != 0) && (sb_addr_i == '0))) begin
      busy_d[sb_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Read ports. Bypass is suppressed while in reset so that every output is
  // zero for the whole reset window, even with writes still being presented.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data_o[r*DATA_W +: DATA_W] = mem_q[rd_addr[r]];
      rd_busy_o[r]                  = busy_q[rd_addr[r]];
      if ((BYPASS != 0) && rst_ni) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_live[p] && (wr_addr[p] == rd_addr[r])) begin
            rd_data_o[r*DATA_W +: DATA_W] = wr_data[p];
            rd_busy_o[r]                  = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[r] == '0)) begin
        rd_data_o[r*DATA_W +: DATA_W] = '0;
        rd_busy_o[r]                  = 1'b0;
      end
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Drives two regfile_mp instances (BYPASS=1 and BYPASS=0) with identical
// stimulus: directed scenarios with literal expectations, then randomized
// traffic. A behavioural model (plain arrays) predicts every output and a
// compare process checks both instances on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = '0;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [31:0] busy_vec_a, busy_vec_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .busy_vec_o(busy_vec_a)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .busy_vec_o(busy_vec_b)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= '0;
      m_busy <= '0;
    end else begin
      // later port overrides earlier one for a shared address
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_addr[p*5 +: 5] != 5'd0) begin
          m_mem[wr_addr[p*5 +: 5]]  <= wr_data[p*32 +: 32];
          m_busy[wr_addr[p*5 +: 5]] <= 1'b0;
        end
      end
      if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] <= 1'b1;
    end
  end

  function automatic bit wrote(input logic [4:0] a);
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p*5 +: 5] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return 32'h0;
    if (byp)
      for (int p = 1; p >= 0; p--)
        if (wr_en[p] && wr_addr[p*5 +: 5] == a) return wr_data[p*32 +: 32];
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return 1'b0;
    if (byp && wrote(a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      check("model rd_data_a", 64'(rd_data_a[r*32 +: 32]), 64'(exp_rd(rd_addr[r*5 +: 5], 1'b1)));
      check("model rd_data_b", 64'(rd_data_b[r*32 +: 32]), 64'(exp_rd(rd_addr[r*5 +: 5], 1'b0)));
      check("model rd_busy_a", 64'(rd_busy_a[r]), 64'(exp_busy(rd_addr[r*5 +: 5], 1'b1)));
      check("model rd_busy_b", 64'(rd_busy_b[r]), 64'(exp_busy(rd_addr[r*5 +: 5], 1'b0)));
    end
    check("model busy_vec_a", 64'(busy_vec_a), rst_n ? 64'(m_busy) : 64'h0);
    check("model busy_vec_b", 64'(busy_vec_b), rst_n ? 64'(m_busy) : 64'h0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    sb_set = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*5 +: 5]   = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input int r, input logic [4:0] a);
    rd_addr[r*5 +: 5] = a;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset held with reads and writes being presented.
    idle();
    set_wr(0, 5'd4, 32'hCAFE0001);
    set_wr(1, 5'd6, 32'hCAFE0002);
    set_rd(0, 5'd4);
    set_rd(1, 5'd6);
    repeat (3) tick();
    #2;
    $display("reset held: rd x4 x6");
    check("reset rd_data_a", rd_data_a, 64'h0);
    check("reset rd_data_b", rd_data_b, 64'h0);
    check("reset rd_busy_a", 64'(rd_busy_a), 64'h0);
    check("reset busy_vec_a", 64'(busy_vec_a), 64'h0);

    // Release, then write x0 and read it.
    tick();
    rst_n = 1'b1;
    idle();
    set_wr(0, 5'd0, 32'hDEADBEEF);
    set_rd(0, 5'd0);
    #2;
    $display("write x0=deadbeef");
    check("x0 bypass", 64'(rd_data_a[31:0]), 64'h0);
    tick();
    idle();
    #2;
    check("x0 after write", 64'(rd_data_a[31:0]), 64'h0);

    // Basic dual write then read.
    set_wr(0, 5'd5, 32'h12345678);
    set_wr(1, 5'd31, 32'hA5A5A5A5);
    tick();
    idle();
    set_rd(0, 5'd5);
    set_rd(1, 5'd31);
    #2;
    $display("write x5=12345678 x31=a5a5a5a5, read back");
    check("x5 read", 64'(rd_data_a[31:0]), 64'h12345678);
    check("x31 read", 64'(rd_data_a[63:32]), 64'hA5A5A5A5);
    check("x31 read nobyp", 64'(rd_data_b[63:32]), 64'hA5A5A5A5);

    // Write conflict with bypass.
    set_wr(0, 5'd7, 32'h77);
    tick();
    idle();
    set_wr(0, 5'd7, 32'h1);
    set_wr(1, 5'd7, 32'h2);
    set_rd(0, 5'd7);
    #2;
    $display("conflict write x7 p0=1 p1=2");
    check("conflict bypass", 64'(rd_data_a[31:0]), 64'h2);
    check("conflict nobyp old", 64'(rd_data_b[31:0]), 64'h77);
    tick();
    idle();
    #2;
    check("conflict stored", 64'(rd_data_a[31:0]), 64'h2);
    check("conflict stored nobyp", 64'(rd_data_b[31:0]), 64'h2);

    // Scoreboard set, three idle cycles, then retire.
    sb_set  = 1'b1;
    sb_addr = 5'd10;
    set_rd(0, 5'd10);
    #2;
    $display("sb_set x10");
    check("sb no same-cycle path", 64'(rd_busy_a[0]), 64'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      #2;
      check("sb busy_vec[10]", 64'(busy_vec_a[10]), 64'h1);
      check("sb rd_busy", 64'(rd_busy_a[0]), 64'h1);
      tick();
    end
    set_wr(0, 5'd10, 32'h55);
    #2;
    $display("write x10=55 retiring producer");
    check("retire rd_busy bypass", 64'(rd_busy_a[0]), 64'h0);
    check("retire rd_busy nobyp", 64'(rd_busy_b[0]), 64'h1);
    check("retire busy_vec still", 64'(busy_vec_a[10]), 64'h1);
    check("retire rd_data bypass", 64'(rd_data_a[31:0]), 64'h55);
    tick();
    idle();
    #2;
    check("retired busy_vec", 64'(busy_vec_a[10]), 64'h0);
    check("retired data", 64'(rd_data_b[31:0]), 64'h55);

    // Set/clear collision.
    set_wr(0, 5'd3, 32'h33);
    sb_set  = 1'b1;
    sb_addr = 5'd3;
    tick();
    idle();
    set_rd(0, 5'd3);
    #2;
    $display("write x3=33 with sb_set x3");
    check("collision busy_vec[3]", 64'(busy_vec_a[3]), 64'h1);
    check("collision data", 64'(rd_data_a[31:0]), 64'h33);

    // Asynchronous reset mid-stream.
    set_wr(1, 5'd9, 32'hFF);
    tick();
    idle();
    set_rd(0, 5'd9);
    set_rd(1, 5'd3);
    #1;
    check("pre-reset x9", 64'(rd_data_a[31:0]), 64'hFF);
    check("pre-reset busy x3", 64'(rd_busy_a[1]), 64'h1);
    set_wr(0, 5'd9, 32'h1234);
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-cycle");
    check("async rst rd_data", rd_data_a, 64'h0);
    check("async rst rd_busy", 64'(rd_busy_a), 64'h0);
    check("async rst busy_vec", 64'(busy_vec_a), 64'h0);
    tick();
    rst_n = 1'b1;
    idle();
    #2;
    check("post-reset x9", 64'(rd_data_a[31:0]), 64'h0);
    check("post-reset busy_vec", 64'(busy_vec_a), 64'h0);

    // Randomized traffic, with occasional asynchronous reset pulses.
    $display("random phase: 3000 cycles");
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      wr_en = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        wr_addr[p*5 +: 5]   = rnd_addr();
        wr_data[p*32 +: 32] = $urandom();
      end
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 3) == 0)
          rd_addr[r*5 +: 5] = wr_addr[($urandom_range(0, 1))*5 +: 5];
        else
          rd_addr[r*5 +: 5] = rnd_addr();
      end
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = rnd_addr();
    end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    #6;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
